tdm_demux_1to4_2bit: RTL

//  Receive end of the 4-channel, 2-bit time-division link whose transmit end is the 4:1 2-bit mux.

---
 rtl/tdm_pkg.sv | 22 ++
 rtl/tdm_slot_decoder.sv | 24 ++
 rtl/tdm_demux_1to4_2bit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-channel 2-bit TDM link (transmit mux and receive demux).
package tdm_pkg;

  // Default bits per channel symbol, shared with the transmit side
  localparam int unsigned DEFAULT_WIDTH = 2;

  // Slots per frame
  localparam int unsigned SLOTS = 4;

  // Slot index of each channel within a frame
  localparam logic [1:0] CH_U = 2'd0;
  localparam logic [1:0] CH_V = 2'd1;
  localparam logic [1:0] CH_W = 2'd2;
  localparam logic [1:0] CH_X = 2'd3;

  // Receiver framing state
  typedef enum logic [0:0] {
    StHunt,
    StLocked
  } tdm_state_e;

endpackage

// File: rtl/tdm_slot_decoder.sv
// 2-to-4 one-hot write-enable decoder: the demux counterpart of the 4:1 slot mux.
module tdm_slot_decoder
  import tdm_pkg::*;
(
  input  logic [1:0]       slot_i,
  input  logic             en_i,
  output logic [SLOTS-1:0] we_o
);

  // One enable per slot, all low when no symbol is being accepted
  always_comb begin
    we_o = '0;
    if (en_i) begin
      unique case (slot_i)
        CH_U: we_o = 4'b0001;
        CH_V: we_o = 4'b0010;
        CH_W: we_o = 4'b0100;
        CH_X: we_o = 4'b1000;
        default: we_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/tdm_demux_1to4_2bit.sv
// Receive end of the 4-channel TDM link: frame alignment, slot tracking, gap timeout and
// reassembly of each 4-slot frame into registered channel outputs.
module tdm_demux_1to4_2bit
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned GAP_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] u,
  output logic [WIDTH-1:0] v,
  output logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] x,
  output logic             frame_valid,
  output logic             locked,
  output logic [1:0]       slot,
  output logic             sync_err
);

  localparam int unsigned GapW = $clog2(GAP_MAX + 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_MAX - 1);

  tdm_state_e       state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             err_d, err_q;
  logic             fv_q;
  logic [WIDTH-1:0] shadow_q [SLOTS-1];
  logic [WIDTH-1:0] u_q, v_q, w_q, x_q;

  logic             accept;
  logic [1:0]       wr_slot;
  logic [SLOTS-1:0] we;

  // A sync symbol always lands in slot 0, whatever slot was expected
  tdm_slot_decoder u_slot_decoder (
    .slot_i (wr_slot),
    .en_i   (accept),
    .we_o   (we)
  );

  // State register plus slot, gap, shadow and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StHunt;
      slot_q  <= CH_U;
      gap_q   <= '0;
      err_q   <= 1'b0;
      fv_q    <= 1'b0;
      for (int i = 0; i < SLOTS - 1; i++) shadow_q[i] <= '0;
      u_q     <= '0;
      v_q     <= '0;
      w_q     <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
      // we[CH_X] only fires for a non-sync symbol in slot 3, i.e. a complete frame
      fv_q    <= we[CH_X];
      if (we[CH_U]) shadow_q[CH_U] <= din;
      if (we[CH_V]) shadow_q[CH_V] <= din;
      if (we[CH_W]) shadow_q[CH_W] <= din;
      if (we[CH_X]) begin
        u_q <= shadow_q[CH_U];
        v_q <= shadow_q[CH_V];
        w_q <= shadow_q[CH_W];
        x_q <= din;
      end
    end
  end

  // Next-state: sync hunting, slot advance, misplaced-sync and gap-timeout detection
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    gap_d   = gap_q;
    err_d   = 1'b0;
    accept  = 1'b0;
    wr_slot = slot_q;
    unique case (state_q)
      StHunt: begin
        if (din_valid && sync) begin
          accept  = 1'b1;
          wr_slot = CH_U;
          slot_d  = CH_V;
          gap_d   = '0;
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (din_valid) begin
          accept = 1'b1;
          gap_d  = '0;
          if (sync) begin
            // Resynchronise on the new sync; any partial frame is abandoned
            wr_slot = CH_U;
            slot_d  = CH_V;
            err_d   = (slot_q != CH_U);
          end else begin
            slot_d = slot_q + 2'd1;
          end
        end else if (slot_q != CH_U) begin
          // Idle between frames is free; idle inside a frame is timed
          if (gap_q >= GapLast) begin
            err_d   = 1'b1;
            state_d = StHunt;
            slot_d  = CH_U;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StHunt;
        slot_d  = CH_U;
        gap_d   = '0;
      end
    endcase
  end

  // Outputs are straight from registers
  always_comb begin
    locked      = (state_q == StLocked);
    slot        = slot_q;
    sync_err    = err_q;
    frame_valid = fv_q;
    u           = u_q;
    v           = v_q;
    w           = w_q;
    x           = x_q;
  end

endmodule
